hevc_quant_4x4: RTL and testbench

- Scalar quantizer for HEVC 4x4 luma residual coefficients, 8-bit video.
- Sits between forward_transform (producer of the coefficient matrix) and the entropy coder / inverse-quant path.
- Captures one 4x4 coefficient block per handshake and quantizes it serially, one coefficient per cycle, using the HEVC-standard scale table and rounding offsets.
- Presents the level block with a valid/ready handshake.

---
 rtl/hevc_quant_4x4.sv | 214 +++++++++++++++++++++
 tb/tb_hevc_quant_4x4.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_quant_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : hevc_quant_4x4
//  Purpose  : Serial HEVC scalar quantizer for one 4x4 luma residual block
//             (8-bit video). Captures a coefficient block on a valid/ready
//             handshake, quantizes one coefficient per cycle using the
//             standard scale table and intra/inter rounding offsets, and
//             presents the level block with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module hevc_quant_4x4 #(
    parameter int COEFF_W = 16,
    parameter int QP_MAX  = 51
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [COEFF_W-1:0]  coeff_matrix [4][4],
    input  logic        [5:0]          qp,
    input  logic                       is_intra,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [COEFF_W-1:0]  level_matrix [4][4],
    output logic        [4:0]          nonzero_count,
    output logic                       cbf,
    output logic                       out_valid,
    input  logic                       out_ready
);

    // Accumulator width: |c| * Q needs COEFF_W + 15 bits, plus headroom for
    // the rounding offset; 18 extra bits keeps the sum comfortably exact.
    localparam int                  c_ACC_W    = COEFF_W + 18;
    localparam logic [COEFF_W-1:0]  c_LVL_MAX  = {1'b0, {(COEFF_W-1){1'b1}}};
    localparam logic [5:0]          c_QP_MAX   = 6'(QP_MAX);
    localparam logic [7:0]          c_OFF_INTRA = 8'd171;
    localparam logic [7:0]          c_OFF_INTER = 8'd85;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_in_ready;
    logic                        w_out_valid;
    logic                        w_accept;

    logic signed [COEFF_W-1:0]   r_coeff [4][4];
    logic signed [COEFF_W-1:0]   r_level [4][4];
    logic        [3:0]           r_idx;
    logic        [4:0]           r_nz;
    logic        [5:0]           r_qp_rem;
    logic        [3:0]           r_qp_div;
    logic                        r_intra;

    logic        [5:0]           w_qp_eff;
    logic        [5:0]           w_rem;
    logic        [3:0]           w_div;

    logic signed [COEFF_W-1:0]   w_coeff;
    logic        [COEFF_W-1:0]   w_coeff_u;
    logic                        w_neg;
    logic        [COEFF_W-1:0]   w_abs;
    logic        [14:0]          w_q;
    logic        [7:0]           w_base;
    logic        [4:0]           w_sh_off;
    logic        [4:0]           w_sh_q;
    logic        [c_ACC_W-1:0]   w_prod;
    logic        [c_ACC_W-1:0]   w_off;
    logic        [c_ACC_W-1:0]   w_sum;
    logic        [c_ACC_W-1:0]   w_lvl_abs;
    logic        [COEFF_W-1:0]   w_sat;
    logic signed [COEFF_W-1:0]   w_level;

    // ------------------------------------------------------------------
    // QP clamp and divider-free split into qp/6 and qp%6 by repeated
    // subtraction; the results are registered with the block.
    // ------------------------------------------------------------------
    assign w_qp_eff = (qp > c_QP_MAX) ? c_QP_MAX : qp;

    // Repeated subtraction of 6 yields quotient and remainder of qp_eff.
    always_comb begin
        w_rem = w_qp_eff;
        w_div = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (w_rem >= 6'd6) begin
                w_rem = w_rem - 6'd6;
                w_div = w_div + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; in_ready is low in DONE so a block
    // is never accepted on the output-handshake cycle.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = QUANT;
                end
            end
            QUANT: begin
                if (r_idx == 4'd15) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;

    // ------------------------------------------------------------------
    // Quantizer datapath for the coefficient selected by r_idx
    // ------------------------------------------------------------------
    assign w_coeff   = r_coeff[r_idx[3:2]][r_idx[1:0]];
    assign w_coeff_u = $unsigned(w_coeff);
    assign w_neg     = w_coeff[COEFF_W-1];
    // Two's-complement negate in COEFF_W bits: the most negative value maps
    // to its exact unsigned magnitude.
    assign w_abs     = w_neg ? (COEFF_W'(0) - w_coeff_u) : w_coeff_u;

    // Scale factor indexed by qp%6.
    always_comb begin
        w_q = 15'd26214;
        case (r_qp_rem)
            6'd0:    w_q = 15'd26214;
            6'd1:    w_q = 15'd23302;
            6'd2:    w_q = 15'd20560;
            6'd3:    w_q = 15'd18396;
            6'd4:    w_q = 15'd16384;
            6'd5:    w_q = 15'd14564;
            default: w_q = 15'd26214;
        endcase
    end

    // qbits = 19 + qp/6; the offset is pre-shifted by qbits - 9.
    assign w_base    = r_intra ? c_OFF_INTRA : c_OFF_INTER;
    assign w_sh_q    = 5'd19 + 5'(r_qp_div);
    assign w_sh_off  = 5'd10 + 5'(r_qp_div);
    assign w_prod    = c_ACC_W'(w_abs) * c_ACC_W'(w_q);
    assign w_off     = c_ACC_W'(w_base) << w_sh_off;
    assign w_sum     = w_prod + w_off;
    assign w_lvl_abs = w_sum >> w_sh_q;
    assign w_sat     = (w_lvl_abs > c_ACC_W'(c_LVL_MAX)) ? c_LVL_MAX
                                                         : w_lvl_abs[COEFF_W-1:0];
    // A zero magnitude negates to zero, so no negative zero can appear.
    assign w_level   = $signed(w_neg ? (COEFF_W'(0) - w_sat) : w_sat);

    // Block capture, per-coefficient level write-back and nonzero counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= 4'd0;
            r_nz     <= 5'd0;
            r_qp_rem <= 6'd0;
            r_qp_div <= 4'd0;
            r_intra  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_coeff[r][c] <= '0;
                    r_level[r][c] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_coeff  <= coeff_matrix;
                r_qp_rem <= w_rem;
                r_qp_div <= w_div;
                r_intra  <= is_intra;
                r_nz     <= 5'd0;
                r_idx    <= 4'd0;
            end else if (r_state == QUANT) begin
                r_level[r_idx[3:2]][r_idx[1:0]] <= w_level;
                r_nz <= r_nz + 5'(w_level != '0);
                if (r_idx != 4'd15) begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    assign level_matrix  = r_level;
    assign nonzero_count = r_nz;
    assign cbf           = (r_nz != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_hevc_quant_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hevc_quant_4x4
//  Purpose  : Scoreboard bench for hevc_quant_4x4 with directed blocks and
//             hand-computed expected levels.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hevc_quant_4x4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic signed [15:0] coeff_matrix [4][4];
    logic        [5:0]  qp;
    logic               is_intra;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] level_matrix [4][4];
    logic        [4:0]  nonzero_count;
    logic               cbf;
    logic               out_valid;
    logic               out_ready;

    hevc_quant_4x4 #(.COEFF_W(16), .QP_MAX(51)) dut (
        .clk           (clk),
        .reset         (reset),
        .coeff_matrix  (coeff_matrix),
        .qp            (qp),
        .is_intra      (is_intra),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .level_matrix  (level_matrix),
        .nonzero_count (nonzero_count),
        .cbf           (cbf),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    typedef struct {
        int lv [16];
        int nz;
        int acc;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cin  [16];
    int   elv  [16];
    int   enz;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            cin[i] = 0;
            elv[i] = 0;
        end
        enz = 0;
    endtask

    // Present a block, wait (bounded) for acceptance, push the expected result.
    task automatic send(input int q, input bit intra, input bit push, output int acc);
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) coeff_matrix[i/4][i%4] = 16'(cin[i]);
        qp       = 6'(q);
        is_intra = intra;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc = cyc;
        if (push) begin
            e.lv  = elv;
            e.nz  = enz;
            e.acc = acc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) coeff_matrix[i/4][i%4] = 16'sh1234;
        qp       = 6'd5;
        is_intra = ~intra;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    int   valid_cyc  = 0;
    bit   prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid && !prev_valid) valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < 16; i++)
                        chk($sformatf("lvl[%0d]", i), int'(level_matrix[i/4][i%4]), e.lv[i]);
                    chk("nonzero_count", int'(nonzero_count), e.nz);
                    chk("cbf", int'(cbf), (e.nz != 0) ? 1 : 0);
                    chk("latency", valid_cyc - e.acc, 17);
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        qp        = 6'd0;
        is_intra  = 1'b0;
        for (int i = 0; i < 16; i++) coeff_matrix[i/4][i%4] = 16'sd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_nz", int'(nonzero_count), 0);
        chk("rst_cbf", int'(cbf), 0);
        for (int i = 0; i < 16; i++) chk("rst_lvl", int'(level_matrix[i/4][i%4]), 0);

        // qp 22 intra, all 192 -> all 1
        clear_vec();
        for (int i = 0; i < 16; i++) begin cin[i] = 192; elv[i] = 1; end
        enz = 16;
        send(22, 1'b1, 1'b1, a0);
        // same block inter -> all 0
        clear_vec();
        for (int i = 0; i < 16; i++) cin[i] = 192;
        send(22, 1'b0, 1'b1, a0);
        // corners +-1000 -> +-4
        clear_vec();
        cin[0] = 1000; cin[15] = -1000; elv[0] = 4; elv[15] = -4; enz = 2;
        send(22, 1'b1, 1'b1, a0);
        // qp 0 extremes
        clear_vec();
        cin[0] = 32767; cin[1] = -32768; elv[0] = 1638; elv[1] = -1638; enz = 2;
        send(0, 1'b1, 1'b1, a0);
        // qp 60 clamps to 51, then qp 51 directly
        clear_vec();
        cin[6] = 10000; elv[6] = 1; enz = 1;
        send(60, 1'b0, 1'b1, a0);
        send(51, 1'b0, 1'b1, a0);
        // qp 27 intra: Q=18396, qbits=23
        clear_vec();
        cin[3] = -500; cin[10] = 2000; elv[3] = -1; elv[10] = 4; enz = 2;
        send(27, 1'b1, 1'b1, a0);
        // qp 13 inter: Q=23302, qbits=21
        clear_vec();
        cin[9] = 300; cin[12] = -90; elv[9] = 3; elv[12] = -1; enz = 2;
        send(13, 1'b0, 1'b1, a0);

        // Output back-pressure: hold out_ready low for 5 cycles in DONE
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b0;
        clear_vec();
        cin[0] = 1000; cin[15] = -1000; elv[0] = 4; elv[15] = -4; enz = 2;
        send(22, 1'b1, 1'b1, a0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_reach_done", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_lvl0", int'(level_matrix[0][0]), 4);
            chk("hold_lvl15", int'(level_matrix[3][3]), -4);
            chk("hold_nz", int'(nonzero_count), 2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);

        // Back-to-back blocks with out_ready high
        clear_vec();
        for (int i = 0; i < 16; i++) begin cin[i] = 192; elv[i] = 1; end
        enz = 16;
        send(22, 1'b1, 1'b1, a0);
        clear_vec();
        cin[0] = 1000; cin[15] = -1000; elv[0] = 4; elv[15] = -4; enz = 2;
        send(22, 1'b1, 1'b1, a1);
        chk("throughput", a1 - a0, 18);

        // Reset in the middle of QUANT abandons the block
        repeat (20) @(posedge clk);
        clear_vec();
        for (int i = 0; i < 16; i++) cin[i] = 192;
        send(22, 1'b1, 1'b0, a0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_nz", int'(nonzero_count), 0);
        chk("midrst_cbf", int'(cbf), 0);
        for (int i = 0; i < 16; i++) chk("midrst_lvl", int'(level_matrix[i/4][i%4]), 0);
        clear_vec();
        cin[0] = 1000; cin[15] = -1000; elv[0] = 4; elv[15] = -4; enz = 2;
        send(22, 1'b1, 1'b1, a0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
